// File: rtl/bg_sar_trim_ctrl.sv
// Bandgap power-up sequencer and SAR trim loop for idacCoarse.
// Optional macro CMP_CHOP_EN: two comparator passes per bit, the second with inputs swapped.
module bg_sar_trim_ctrl #(
  parameter int IDAC_W     = 8,
  parameter int NDIODE     = 8,
  parameter int PWRUP_CYC  = 64,
  parameter int AZ_CYC     = 8,
  parameter int SETTLE_CYC = 16,
  parameter logic [IDAC_W-1:0] FINE_INIT = IDAC_W'(1 << (IDAC_W - 1))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmpo,
  output logic              busy,
  output logic              done,
  output logic [IDAC_W-1:0] trimCode,
  output logic              pwrup,
  output logic [IDAC_W-1:0] idacCoarse,
  output logic [IDAC_W-1:0] idacFine,
  output logic [NDIODE-1:0] diodeSelect,
  output logic [1:0]        c1,
  output logic [1:0]        c2,
  output logic              cmpZeroOffset,
  output logic              cmpSwapInput
);

  localparam int MAX_PA  = (PWRUP_CYC > AZ_CYC) ? PWRUP_CYC : AZ_CYC;
  localparam int MAX_CYC = (MAX_PA > SETTLE_CYC) ? MAX_PA : SETTLE_CYC;
  localparam int CNT_RAW = $clog2(MAX_CYC + 1);
  localparam int CNT_W   = (CNT_RAW < 2) ? 2 : CNT_RAW;
  localparam int BIT_W   = (IDAC_W > 1) ? $clog2(IDAC_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_AZ, S_SMP_P, S_SMP_N, S_CMP, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIT_W-1:0]   bit_idx, bit_nxt;
  logic [IDAC_W-1:0]  trial, trial_nxt;
  logic [IDAC_W-1:0]  trim_nxt;
  logic               cmpo_p0, cmpo_p1;
  logic               resolve, clr, busy_nxt;
`ifdef CMP_CHOP_EN
  logic               pass, pass_nxt;
  logic               res_a, res_a_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    trial_nxt = trial;
    trim_nxt  = trimCode;
    resolve   = 1'b0;
    clr       = 1'b0;
`ifdef CMP_CHOP_EN
    pass_nxt  = pass;
    res_a_nxt = res_a;
`endif
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_PWRUP;
        cnt_nxt   = CNT_W'(PWRUP_CYC - 1);
        trial_nxt = IDAC_W'(1) << (IDAC_W - 1);
        bit_nxt   = BIT_W'(IDAC_W - 1);
`ifdef CMP_CHOP_EN
        pass_nxt  = 1'b0;
`endif
      end
      S_PWRUP: if (cnt == '0) begin
        state_nxt = S_AZ;
        cnt_nxt   = CNT_W'(AZ_CYC - 1);
      end else cnt_nxt = cnt - 1'b1;
      S_AZ: if (cnt == '0) begin
        state_nxt = S_SMP_P;
        cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
      end else cnt_nxt = cnt - 1'b1;
      S_SMP_P: if (cnt == '0) begin
        state_nxt = S_SMP_N;
        cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
      end else cnt_nxt = cnt - 1'b1;
      S_SMP_N: if (cnt == '0) begin
        state_nxt = S_CMP;
        cnt_nxt   = CNT_W'(2);
      end else cnt_nxt = cnt - 1'b1;
      S_CMP: if (cnt == '0) begin
`ifdef CMP_CHOP_EN
        if (!pass) begin
          pass_nxt  = 1'b1;
          res_a_nxt = cmpo_p1;
          state_nxt = S_SMP_P;
          cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
        end else begin
          // Only a consistent "too high" across both input polarities clears the bit.
          pass_nxt = 1'b0;
          resolve  = 1'b1;
          clr      = res_a & ~cmpo_p1;
        end
`else
        resolve = 1'b1;
        clr     = cmpo_p1;
`endif
      end else cnt_nxt = cnt - 1'b1;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (resolve) begin
      if (clr) trial_nxt[bit_idx] = 1'b0;
      if (bit_idx == '0) begin
        state_nxt = S_DONE;
        trim_nxt  = trial_nxt;
      end else begin
        bit_nxt            = bit_idx - 1'b1;
        trial_nxt[bit_nxt] = 1'b1;
        state_nxt          = S_SMP_P;
        cnt_nxt            = CNT_W'(SETTLE_CYC - 1);
      end
    end

    busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      trial         <= '0;
      cmpo_p0       <= 1'b0;
      cmpo_p1       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      trimCode      <= '0;
      pwrup         <= 1'b0;
      idacCoarse    <= '0;
      idacFine      <= '0;
      diodeSelect   <= '0;
      c1            <= 2'b00;
      c2            <= 2'b00;
      cmpZeroOffset <= 1'b0;
      cmpSwapInput  <= 1'b0;
`ifdef CMP_CHOP_EN
      pass          <= 1'b0;
      res_a         <= 1'b0;
`endif
    end else begin
      // comparator synchroniser stages p0 -> p1
      cmpo_p0       <= cmpo;
      cmpo_p1       <= cmpo_p0;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_idx       <= bit_nxt;
      trial         <= trial_nxt;
      trimCode      <= trim_nxt;
      busy          <= busy_nxt;
      done          <= (state_nxt == S_DONE);
      pwrup         <= (state_nxt != S_IDLE);
      idacCoarse    <= busy_nxt ? trial_nxt : trim_nxt;
      idacFine      <= (state_nxt != S_IDLE) ? FINE_INIT : '0;
      cmpZeroOffset <= (state_nxt == S_AZ);
      diodeSelect   <= (state_nxt == S_SMP_P) ? NDIODE'(1) :
                       (state_nxt == S_SMP_N) ? {NDIODE{1'b1}} : '0;
      c1            <= (state_nxt == S_SMP_P) ? 2'b11 :
                       (state_nxt == S_SMP_N || state_nxt == S_CMP) ? 2'b01 : 2'b00;
      c2            <= (state_nxt == S_SMP_N) ? 2'b11 :
                       (state_nxt == S_CMP) ? 2'b01 : 2'b00;
`ifdef CMP_CHOP_EN
      pass          <= pass_nxt;
      res_a         <= res_a_nxt;
      cmpSwapInput  <= pass_nxt && (state_nxt == S_SMP_P || state_nxt == S_SMP_N ||
                                    state_nxt == S_CMP);
`else
      cmpSwapInput  <= 1'b0;
`endif
    end
  end

endmodule
